branch_predict_unit: RTL

- Parametrised successor to the pipeline's combinational branch-resolution logic.
- Owns a direct-mapped branch target buffer (BTB) with per-entry N-bit saturating counters and looks up predictions for the fetch PC.
- Resolves branches, jumps and RETI from execute and raises pipe flushes and PC redirects.
- Handles single-level IRQ entry/return with an internal saved-PC (EPC) register. Sits between fetch, execute and the VIC.

---
 rtl/branch_predict_unit.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/branch_predict_unit.sv
// Branch prediction and resolution unit.
// Holds a direct-mapped BTB with saturating counters. It resolves branches,
// jumps and RETI coming back from execute, and it handles single-level IRQ
// entry and return through a saved-PC (EPC) register.
//
// Events that produce a redirect, in priority order:
// event       | NPC | RedirectPC
// IRQ accept  | 11  | IRQ_VECTOR
// RETI        | 10  | EPC
// mispredict  | 01  | ResTaken ? ResTarget : ResPC+4
// none        | 00  | 0
module branch_predict_unit #(
   parameter int unsigned          ADDR_W     = 32,
   parameter int unsigned          ENTRIES    = 16,
   parameter int unsigned          CNT_W      = 2,
   parameter logic [ADDR_W-1:0]    IRQ_VECTOR = 32'h0000_0010,
   parameter int unsigned          STAT_W     = 16
) (
   input  logic              CLK,
   input  logic              Reset,
   input  logic [ADDR_W-1:0] FetchPC,
   output logic              PredHit,
   output logic              PredTaken,
   output logic [ADDR_W-1:0] PredTarget,
   input  logic              ResValid,
   input  logic [ADDR_W-1:0] ResPC,
   input  logic              ResBranch,
   input  logic              ResJump,
   input  logic              ResReti,
   input  logic              ResTaken,
   input  logic [ADDR_W-1:0] ResTarget,
   input  logic              ResPredTaken,
   input  logic [ADDR_W-1:0] ResPredTarget,
   input  logic              IRQ,
   output logic              IrqAck,
   output logic              InIsr,
   output logic              FlushPipePC,
   output logic [1:0]        NPC,
   output logic [ADDR_W-1:0] RedirectPC,
   output logic [STAT_W-1:0] MispredCount
);

   localparam int unsigned IDX_W = $clog2(ENTRIES);
   localparam int unsigned TAG_W = ADDR_W - IDX_W - 2;
   localparam logic [CNT_W-1:0] CNT_MAX  = '1;
   localparam logic [CNT_W-1:0] CNT_WEAK = CNT_W'(2 ** (CNT_W - 1));

   logic [ENTRIES-1:0] r_valid;
   logic [TAG_W-1:0]   r_tag    [ENTRIES];
   logic [ADDR_W-1:0]  r_target [ENTRIES];
   logic [CNT_W-1:0]   r_cnt    [ENTRIES];
   logic [ADDR_W-1:0]  r_epc;
   logic               r_in_isr;
   logic [STAT_W-1:0]  r_mispred_cnt;

   logic [IDX_W-1:0]  w_fidx;
   logic [TAG_W-1:0]  w_ftag;
   logic              w_fhit;
   logic [IDX_W-1:0]  w_ridx;
   logic [TAG_W-1:0]  w_rtag;
   logic              w_rhit;
   logic              w_ctl;
   logic              w_reti;
   logic              w_taken;
   logic              w_mispred;
   logic [ADDR_W-1:0] w_mis_pc;
   logic              w_irq_acc;
   logic              w_unused;

   // The low PC bits only select bytes inside a word, so they never index the table.
   assign w_unused = ^{FetchPC[1:0], ResPC[1:0]};

   assign w_fidx = FetchPC[IDX_W+1:2];
   assign w_ftag = FetchPC[ADDR_W-1:IDX_W+2];
   assign w_fhit = r_valid[w_fidx] && (r_tag[w_fidx] == w_ftag);

   assign w_ridx = ResPC[IDX_W+1:2];
   assign w_rtag = ResPC[ADDR_W-1:IDX_W+2];
   assign w_rhit = r_valid[w_ridx] && (r_tag[w_ridx] == w_rtag);

   assign w_ctl     = ResValid && (ResBranch || ResJump);
   assign w_reti    = ResValid && ResReti;
   assign w_taken   = ResTaken || ResJump;
   assign w_mispred = w_ctl && ((w_taken != ResPredTaken) ||
                                (w_taken && (ResTarget != ResPredTarget)));
   assign w_mis_pc  = w_taken ? ResTarget : (ResPC + ADDR_W'(4));
   assign w_irq_acc = IRQ && !r_in_isr && !w_reti;

   assign InIsr        = r_in_isr;
   assign MispredCount = r_mispred_cnt;

   // Fetch-side lookup. The read uses stored state only, so a write in the same cycle is not visible yet.
   always_comb begin
      PredHit    = 1'b0;
      PredTaken  = 1'b0;
      PredTarget = '0;
      if (!Reset && w_fhit) begin
         PredHit    = 1'b1;
         PredTaken  = r_cnt[w_fidx][CNT_W-1];
         PredTarget = r_target[w_fidx];
      end
   end

   // Redirect selection. An IRQ outranks a mispredict, and a RETI blocks the IRQ inside w_irq_acc.
   always_comb begin
      FlushPipePC = 1'b0;
      NPC         = 2'b00;
      RedirectPC  = '0;
      IrqAck      = 1'b0;
      if (!Reset) begin
         if (w_irq_acc) begin
            FlushPipePC = 1'b1;
            NPC         = 2'b11;
            RedirectPC  = IRQ_VECTOR;
            IrqAck      = 1'b1;
         end else if (w_reti) begin
            FlushPipePC = 1'b1;
            NPC         = 2'b10;
            RedirectPC  = r_epc;
         end else if (w_mispred) begin
            FlushPipePC = 1'b1;
            NPC         = 2'b01;
            RedirectPC  = w_mis_pc;
         end
      end
   end

   // BTB update from resolved branches and jumps. The update still happens when an IRQ takes the redirect.
   always_ff @(posedge CLK) begin
      if (Reset) begin
         r_valid <= '0;
      end else if (w_ctl) begin
         if (w_rhit) begin
            if (ResJump)
               r_cnt[w_ridx] <= CNT_MAX;
            else if (w_taken)
               r_cnt[w_ridx] <= (r_cnt[w_ridx] == CNT_MAX) ? CNT_MAX : r_cnt[w_ridx] + CNT_W'(1);
            else
               r_cnt[w_ridx] <= (r_cnt[w_ridx] == '0) ? '0 : r_cnt[w_ridx] - CNT_W'(1);
            if (w_taken)
               r_target[w_ridx] <= ResTarget;
         end else if (w_taken) begin
            r_valid[w_ridx]  <= 1'b1;
            r_tag[w_ridx]    <= w_rtag;
            r_target[w_ridx] <= ResTarget;
            r_cnt[w_ridx]    <= ResJump ? CNT_MAX : CNT_WEAK;
         end
      end
   end

   // ISR state, saved PC and the saturating mispredict statistic.
   always_ff @(posedge CLK) begin
      if (Reset) begin
         r_epc         <= '0;
         r_in_isr      <= 1'b0;
         r_mispred_cnt <= '0;
      end else begin
         if (w_irq_acc) begin
            // If a mispredict coincides with the IRQ, return to the corrected path.
            r_epc    <= w_mispred ? w_mis_pc : FetchPC;
            r_in_isr <= 1'b1;
         end else if (w_reti) begin
            r_in_isr <= 1'b0;
         end
         if (w_mispred && (r_mispred_cnt != '1))
            r_mispred_cnt <= r_mispred_cnt + STAT_W'(1);
      end
   end

endmodule
